// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: byte FIFO feeding an 11-bit frame serializer that drives ps2_clk/ps2_data.
// Optional host clock-inhibit abort/retry is enabled by defining PS2_TX_INHIBIT_EN.
module ps2_device_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
`ifdef PS2_TX_INHIBIT_EN
  input  logic       host_inhibit,
`endif
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HIGH, BIT_LOW, GAP} state_t;

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, push, pop;

  state_t        state;
  logic [10:0]   shreg;
  logic [3:0]    bit_idx;
  logic [CW-1:0] cnt;

  logic [7:0]    load_byte;
  logic          start_ok, abort, pending;

  assign fifo_empty = (count == '0);
  assign tx_ready   = (count != FULL_CNT);
  assign push       = tx_valid & tx_ready;

`ifdef PS2_TX_INHIBIT_EN
  logic       retry_valid;
  logic [7:0] retry_byte;

  assign load_byte = retry_valid ? retry_byte : mem[rd_ptr];
  assign start_ok  = !host_inhibit && (retry_valid || !fifo_empty);
  assign pending   = retry_valid || !fifo_empty;
  assign pop       = (state == LOAD) && !retry_valid;
  // Once bit 10 has started the frame is committed; bit_idx is stale in LOAD, hence the explicit term.
  assign abort     = host_inhibit &&
                     ((state == LOAD) ||
                      ((state == BIT_HIGH || state == BIT_LOW) && bit_idx != 4'd10));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_valid <= 1'b0;
      retry_byte  <= '0;
    end else begin
      if (state == LOAD) retry_byte <= load_byte;
      if (abort)               retry_valid <= 1'b1;
      else if (state == LOAD)  retry_valid <= 1'b0;
    end
  end
`else
  assign load_byte = mem[rd_ptr];
  assign start_ok  = !fifo_empty;
  assign pending   = !fifo_empty;
  assign pop       = (state == LOAD);
  assign abort     = 1'b0;
`endif

  // NOTE: storage has no reset; validity is tracked solely by count and the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
    end else if (abort) begin
      state    <= IDLE;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b1;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          busy     <= pending;
          if (start_ok) state <= LOAD;
        end
        LOAD: begin
          shreg    <= {1'b1, ~^load_byte, load_byte, 1'b0};
          ps2_data <= 1'b0;
          bit_idx  <= '0;
          cnt      <= '0;
          busy     <= 1'b1;
          state    <= BIT_HIGH;
        end
        BIT_HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            ps2_clk <= 1'b0;
            state   <= BIT_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_LOW: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            ps2_clk <= 1'b1;
            if (bit_idx == 4'd10) begin
              ps2_data <= 1'b1;
              state    <= GAP;
            end else begin
              shreg    <= shreg >> 1;
              ps2_data <= shreg[1];
              bit_idx  <= bit_idx + 1'b1;
              state    <= BIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= pending;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: expected 11-bit frames are queued at issue time and a
// monitor decodes ps2_data on every ps2_clk falling edge. Define PS2_TX_INHIBIT_EN for the abort test.
module tb_ps2_device_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int GAP_CYCLES = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk, ps2_data, busy;
  logic       line_hold;

`ifdef PS2_TX_INHIBIT_EN
  logic host_inhibit = 1'b0;
  assign line_hold = host_inhibit;
`else
  assign line_hold = 1'b0;
`endif

  ps2_device_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef PS2_TX_INHIBIT_EN
    .host_inhibit(host_inhibit),
`endif
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state shared between stimulus and monitor.
  logic [10:0] exp_q[$];
  int unsigned t0_q[$];
  int          frames_done = 0;
  int          falls = 0;
  int          bit_n = 0;
  logic [10:0] cap = '0;
  logic        prev_clk = 1'b1, prev_data = 1'b1;
  int unsigned last_fall = 0;

  always @(negedge clock) begin
    if (reset || line_hold) begin
      bit_n = 0;
    end else begin
      if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
        falls++;
        if (bit_n == 0) t0_q.push_back(cyc);
        else check("fall_spacing", cyc - last_fall, 2 * CLK_DIV);
        last_fall  = cyc;
        cap[bit_n] = ps2_data;
        bit_n++;
        if (bit_n == 11) begin
          bit_n = 0;
          frames_done++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got %b, expected no frame", cap);
          end else begin
            check("frame", cap, exp_q.pop_front());
          end
        end
      end else if (prev_clk === 1'b0 && ps2_clk === 1'b0) begin
        check("data_stable_low", ps2_data, prev_data);
      end
    end
    prev_clk  = ps2_clk;
    prev_data = ps2_data;
  end

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("frames_by_deadline", 32'(frames_done >= target), 1);
  endtask

  task automatic wait_bits(input int target, input int budget);
    int n = 0;
    while (bit_n != target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("bit_reached", 32'(bit_n), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("idle_by_deadline", 32'(busy), 0);
  endtask

  // Frames are {stop, parity, data, start}; bit 0 goes on the wire first.
  localparam logic [10:0] FRAME_1C = 11'b10000111000;
  localparam logic [10:0] FRAME_F0 = 11'b11111100000;
  localparam logic [10:0] FRAME_1B = 11'b11000110110;

  initial begin
    int unsigned t_push;
    int n;
    int falls_before;
    logic [8:0] seq_par;
    seq_par = 9'b001101001;  // odd parity of 0x00..0x08, indexed by the byte value

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_ps2_clk", 32'(ps2_clk), 1);
    check("rst_ps2_data", 32'(ps2_data), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_ready", 32'(tx_ready), 1);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Single 0x1C: latency, spacing, busy window
    t0_q.delete();
    exp_q.push_back(FRAME_1C);
    push_byte(8'h1C);
    t_push = cyc;
    n = 0;
    while (t0_q.size() == 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("first_fall_seen", 32'(t0_q.size()), 1);
    if (t0_q.size() > 0) check("first_fall_latency", t0_q[0] - t_push, 6);
    check("busy_mid_frame", 32'(busy), 1);
    wait_idle(200);
    check("busy_drop_time", cyc - t_push, 98);
    wait_frames(1, 50);

    // Single 0xF0
    exp_q.push_back(FRAME_F0);
    push_byte(8'hF0);
    wait_frames(2, 200);
    wait_idle(200);

    // Back-to-back 0x1C, 0xF0, 0x1C
    t0_q.delete();
    exp_q.push_back(FRAME_1C);
    push_byte(8'h1C);
    exp_q.push_back(FRAME_F0);
    push_byte(8'hF0);
    exp_q.push_back(FRAME_1C);
    push_byte(8'h1C);
    wait_frames(5, 500);
    check("b2b_frame_count", 32'(t0_q.size()), 3);
    if (t0_q.size() == 3) begin
      check("b2b_spacing_1", t0_q[1] - t0_q[0], 98);
      check("b2b_spacing_2", t0_q[2] - t0_q[1], 98);
    end
    wait_idle(200);

    // Overflow: 12 presented bytes, only 0x00..0x08 fit (8 buffered + 1 in flight)
    for (int i = 0; i < 12; i++) begin
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      check($sformatf("ovf_ready_%0d", i), 32'(tx_ready), 32'(i <= 8));
      if (i <= 8) exp_q.push_back({1'b1, seq_par[i], 8'(i), 1'b0});
      @(negedge clock);
    end
    tx_valid = 1'b0;
    wait_frames(14, 1500);
    wait_idle(300);
    repeat (150) @(negedge clock);
    check("ovf_no_extra_frames", 32'(frames_done), 14);

    // Reset during bit 5 of 0x1B with two more bytes buffered: everything discarded
    push_byte(8'h1B);
    push_byte(8'hF0);
    push_byte(8'h1C);
    wait_bits(6, 200);
    check("pre_rst_clk_low", 32'(ps2_clk), 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ps2_clk", 32'(ps2_clk), 1);
    check("async_rst_ps2_data", 32'(ps2_data), 1);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_tx_ready", 32'(tx_ready), 1);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    falls_before = falls;
    repeat (250) @(negedge clock);
    check("post_rst_no_edges", 32'(falls), 32'(falls_before));
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_frames", 32'(frames_done), 14);

`ifdef PS2_TX_INHIBIT_EN
    // Inhibit during bit 3 of 0x1B; the same byte must be resent before 0x1C
    exp_q.push_back(FRAME_1B);
    push_byte(8'h1B);
    exp_q.push_back(FRAME_1C);
    push_byte(8'h1C);
    wait_bits(4, 200);
    host_inhibit = 1'b1;
    falls_before = falls;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 48; i++) begin
      if (i % 12 == 0) begin
        check("inh_ps2_clk_high", 32'(ps2_clk), 1);
        check("inh_ps2_data_high", 32'(ps2_data), 1);
        check("inh_busy", 32'(busy), 1);
      end
      @(negedge clock);
    end
    check("inh_no_edges", 32'(falls), 32'(falls_before));
    host_inhibit = 1'b0;
    wait_frames(16, 500);
    wait_idle(200);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Synthesizable PS/2 device-side transmitter; the keyboard end of the link whose host end is our `ps2_keyboard` receiver.
- Accepts scan-code bytes over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as an 11-bit PS/2 frame, generating both `ps2_clk` and `ps2_data`.
- Replaces the behavioural keyboard model in SimTop so the receiver can be exercised in synthesizable sims and on board.

Parameters:
- CLK_DIV, 4: system cycles per ps2_clk half-period (high phase and low phase each); legal range ≥2.
- FIFO_DEPTH, 8: byte FIFO entries; power of two, ≥2.
- GAP_CYCLES, 8: idle cycles (clk high, data high) inserted after each frame; ≥1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data  input  8  scan-code byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept; push occurs when tx_valid & tx_ready at a clock edge.
- ps2_clk  output  1  PS/2 clock to host; idle high.
- ps2_data  output  1  PS/2 data to host; idle high.
- busy  output  1  high when a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (async, immediate):
  - ps2_clk=1, ps2_data=1, busy=0, tx_ready=1.
  - FIFO emptied, FSM forced to IDLE, counters cleared.
  - Reset mid-frame truncates the frame immediately; the partial frame and all buffered bytes are discarded.
- Outputs: ps2_clk, ps2_data and busy are registered. tx_ready = !fifo_full, computed from the registered count.
- FIFO push/pop:
  - Push when tx_valid & tx_ready.
  - Pop occurs in the LOAD cycle.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle (tx_ready is already 0).
  - When not full, a simultaneous push and pop leaves the count unchanged.
- Frame format, shifted out LSB first:
  - bit0 start = 0.
  - bits1-8 = data[0..7].
  - bit9 = odd parity, i.e. ~^data; the total number of ones in data plus parity is odd.
  - bit10 stop = 1.
- FSM states: IDLE, LOAD, BIT_HIGH, BIT_LOW, GAP.
- IDLE:
  - ps2_clk=1, ps2_data=1.
  - If the FIFO is non-empty, go to LOAD next cycle.
- LOAD (1 cycle):
  - Pop the head byte into an 11-bit shift register.
  - Drive ps2_data = start bit; bit index = 0.
  - Go to BIT_HIGH.
- BIT_HIGH:
  - ps2_clk=1; ps2_data holds the current bit.
  - After CLK_DIV cycles, go to BIT_LOW and drive ps2_clk=0.
  - The host samples on this falling edge, so setup is CLK_DIV cycles.
- BIT_LOW:
  - ps2_clk=0 for CLK_DIV cycles; ps2_data is stable throughout.
  - On exit, ps2_clk=1.
  - If bit index < 10: shift, increment the index, present the next bit, go to BIT_HIGH.
  - If bit index = 10: ps2_data=1, go to GAP.
- GAP:
  - Lines high for GAP_CYCLES cycles, then IDLE.
  - Back-to-back bytes: IDLE→LOAD adds 2 cycles, so the frame-start-to-frame-start spacing is 22·CLK_DIV + GAP_CYCLES + 2 cycles.
- Latency:
  - A byte pushed into an empty FIFO while idle at edge N appears as start bit on ps2_data at edge N+2 (IDLE sees non-empty at N+1, LOAD at N+2).
  - First falling ps2_clk edge occurs CLK_DIV cycles later.
- Data never changes while ps2_clk=0.
- busy is asserted from the cycle after the first push until the GAP→IDLE transition with the FIFO empty.

Optional Feature:
- Macro PS2_TX_INHIBIT_EN.
- When defined:
  - Adds input port host_inhibit (1 bit), placed after reset; it models the host holding the clock low.
  - In IDLE, with host_inhibit=1, no frame starts.
  - If host_inhibit rises during LOAD/BIT_HIGH/BIT_LOW before bit index 10 completes, the frame is aborted: lines are driven high, the popped byte is held in a retry register, and the FSM waits in IDLE.
  - After host_inhibit falls, the same byte is retransmitted before any FIFO byte.
  - Inhibit during bit 10 or GAP is ignored for the current frame.
- When undefined: the port is absent and frames are never aborted.

Test Plan:
- Reset with CLK_DIV=4, GAP_CYCLES=8, then push 0x1C → ps2_data sampled at the 11 ps2_clk falling edges = 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Falling edges are 8 cycles apart, first at push+6. busy drops at push+2+88+8.
- Push 0xF0 → sampled bits 0,0,0,0,0,1,1,1,1,1,1 (parity 1).
- Push 0x1C, 0xF0, 0x1C back-to-back → three frames, start-to-start spacing 98 cycles, no lost or reordered bytes. Connecting our `ps2_keyboard` receiver yields 0x1C, 0xF0, 0x1C.
- Hold tx_valid for 12 pushes (0x00..0x0B) while the first frame is in flight → tx_ready=0 after 8 buffered plus 1 in flight. Accepted bytes are transmitted in order and the refused bytes are never sent.
- Assert reset during bit 5 of a 0x1B frame → ps2_clk=1 and ps2_data=1 before the next clock edge, busy=0, FIFO empty, no further edges.
- (PS2_TX_INHIBIT_EN) Raise host_inhibit during bit 3 of 0x1B, release 50 cycles later → lines high while inhibited, then a full 0x1B frame (parity 1) precedes the next FIFO byte.
